// File: rtl/irq_ctrl_if.sv
// Bridge register port plus the CPU interrupt request/acknowledge handshake.
// The controller is the slave; the bus/CPU side is the master.
interface irq_ctrl_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        int_ack;
    logic [5:0]  hw_int;
    logic        int_req;

    modport master (
        output sel, we, addr, din, int_ack,
        input  dout, hw_int, int_req
    );

    modport slave (
        input  sel, we, addr, din, int_ack,
        output dout, hw_int, int_req
    );
endinterface

// File: rtl/irq_ctrl.sv
// Six-line interrupt controller: latch, mask, prioritise (lowest index wins) and
// present one request at a time to the CPU, with ack / end-of-interrupt sequencing.
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    irq_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cur_id_q, cur_id_d;
    logic [N_SRC-1:0] irq_q, irq_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] cur_onehot;
    logic [N_SRC-1:0] pend_clr;
    logic [2:0]       lowest_id;
    logic             wr;
    logic             pend_wr;
    logic             eoi_wr;
    logic             ack_hit;
    logic             unused_din;

    assign wr      = bus.sel & bus.we;
    assign pend_wr = wr & (bus.addr == 2'd0);
    assign eoi_wr  = wr & (bus.addr == 2'd3);
    assign ack_hit = bus.int_ack & (state_q == REQ);

    assign irq_d      = irq_in;
    assign rise       = irq_in & ~irq_q;
    assign eligible   = pend_q & mask_q;
    assign cur_onehot = N_SRC'(1) << cur_id_q;
    assign unused_din = ^bus.din[31:N_SRC];

    // Edge bits: a new rise always survives a same-cycle clear; level bits just follow the line.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
        assign pend_clr[gi] = (pend_wr & bus.din[gi]) | (ack_hit & (cur_id_q == 3'(gi)));
        assign pend_d[gi]   = mode_q[gi] ? (rise[gi] | (pend_q[gi] & ~pend_clr[gi]))
                                         : irq_in[gi];
    end

    assign mask_d = (wr && bus.addr == 2'd1) ? bus.din[N_SRC-1:0] : mask_q;
    assign mode_d = (wr && bus.addr == 2'd2) ? bus.din[N_SRC-1:0] : mode_q;

    always_comb begin
        lowest_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lowest_id = 3'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    cur_id_d = lowest_id;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    state_d = SERVICE;
                end else if ((eligible & cur_onehot) == '0) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cur_id_q <= '0;
            irq_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            mode_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            irq_q    <= irq_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
        end
    end

    // Outputs decode registered state only, so they cannot glitch.
    assign bus.hw_int  = (state_q == REQ) ? cur_onehot : '0;
    assign bus.int_req = (state_q == REQ);

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            2'd0: bus.dout[N_SRC-1:0] = pend_q;
            2'd1: bus.dout[N_SRC-1:0] = mask_q;
            2'd2: bus.dout[N_SRC-1:0] = mode_q;
            2'd3: bus.dout = {22'b0, state_q == SERVICE, state_q == REQ, 5'b0, cur_id_q};
            default: bus.dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a vector table covers masking, priority, ack/EOI and
// set-beats-clear; hand-written sequences cover reset at start and mid-service.
module tb_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] irq_in;

    irq_ctrl_if bus ();

    irq_ctrl #(.N_SRC(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [5:0]  irq;
        logic        ack;
        logic [5:0]  exp_hw;
        logic [31:0] exp_dout;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [31:0] din,
                                input logic [5:0] irq, input logic ack,
                                input logic [5:0] exp_hw, input logic [31:0] exp_dout);
        vec_t v;
        v.we = we; v.addr = addr; v.din = din; v.irq = irq; v.ack = ack;
        v.exp_hw = exp_hw; v.exp_dout = exp_dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic we, input logic [1:0] addr, input logic [31:0] din,
                        input logic [5:0] irq, input logic ack);
        @(negedge clk);
        bus.sel     = we;
        bus.we      = we;
        bus.addr    = addr;
        bus.din     = din;
        bus.int_ack = ack;
        irq_in      = irq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we addr din irq ack | exp_hw exp_dout
        vecs[0]  = mk(1, 2, 32'h01, 6'h00, 0, 6'h00, 32'h001); // edge mode for bit0
        vecs[1]  = mk(0, 0, 32'h00, 6'h01, 0, 6'h00, 32'h001); // masked pulse latches
        vecs[2]  = mk(0, 0, 32'h00, 6'h00, 0, 6'h00, 32'h001); // edge pend holds
        vecs[3]  = mk(1, 1, 32'h01, 6'h00, 0, 6'h00, 32'h001); // unmask bit0
        vecs[4]  = mk(0, 3, 32'h00, 6'h00, 0, 6'h01, 32'h100); // presented next cycle
        vecs[5]  = mk(0, 0, 32'h00, 6'h00, 1, 6'h00, 32'h000); // ack clears edge pend
        vecs[6]  = mk(1, 3, 32'h00, 6'h00, 0, 6'h00, 32'h000); // EOI
        vecs[7]  = mk(1, 2, 32'h00, 6'h00, 0, 6'h00, 32'h000); // all level
        vecs[8]  = mk(1, 1, 32'h3F, 6'h00, 0, 6'h00, 32'h03F); // unmask all
        vecs[9]  = mk(0, 0, 32'h00, 6'h06, 0, 6'h00, 32'h006); // bits1,2 raised
        vecs[10] = mk(0, 3, 32'h00, 6'h06, 0, 6'h02, 32'h101); // lowest wins
        vecs[11] = mk(0, 3, 32'h00, 6'h06, 1, 6'h00, 32'h201); // ack -> service
        vecs[12] = mk(0, 0, 32'h00, 6'h06, 1, 6'h00, 32'h006); // ack ignored in service
        vecs[13] = mk(1, 3, 32'h00, 6'h06, 0, 6'h00, 32'h001); // EOI -> idle
        vecs[14] = mk(0, 3, 32'h00, 6'h06, 0, 6'h02, 32'h101); // bit1 again
        vecs[15] = mk(0, 3, 32'h00, 6'h04, 1, 6'h00, 32'h201); // drop bit1 + ack
        vecs[16] = mk(1, 3, 32'h00, 6'h04, 0, 6'h00, 32'h001); // EOI
        vecs[17] = mk(0, 3, 32'h00, 6'h04, 0, 6'h04, 32'h102); // bit2 presented
        vecs[18] = mk(0, 3, 32'h00, 6'h00, 0, 6'h04, 32'h102); // drop seen via pend next
        vecs[19] = mk(0, 3, 32'h00, 6'h00, 0, 6'h00, 32'h002); // withdrawn -> idle
        vecs[20] = mk(0, 3, 32'h00, 6'h00, 1, 6'h00, 32'h002); // ack in idle ignored
        vecs[21] = mk(1, 2, 32'h02, 6'h00, 0, 6'h00, 32'h002); // bit1 edge mode
        vecs[22] = mk(1, 0, 32'h02, 6'h02, 0, 6'h00, 32'h002); // rise beats W1C
        vecs[23] = mk(0, 0, 32'h00, 6'h02, 0, 6'h02, 32'h002); // bit1 presented
        vecs[24] = mk(0, 0, 32'h00, 6'h02, 1, 6'h00, 32'h000); // ack clears edge bit1
        vecs[25] = mk(0, 0, 32'h00, 6'h05, 0, 6'h00, 32'h005); // pend = 05 in service

        reset = 1'b0;
        irq_in = 6'h3F;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.din = '0; bus.int_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        irq_in = 6'h00;
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            #1;
            chk($sformatf("reset_dout_a%0d", a), bus.dout, 32'h0);
        end
        chk("reset_hw_int", {26'b0, bus.hw_int}, 32'h0);
        chk("reset_int_req", {31'b0, bus.int_req}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].irq, vecs[i].ack);
            chk($sformatf("v%0d_hw_int", i), {26'b0, bus.hw_int}, {26'b0, vecs[i].exp_hw});
            chk($sformatf("v%0d_int_req", i), {31'b0, bus.int_req}, {31'b0, |vecs[i].exp_hw});
            chk($sformatf("v%0d_dout", i), bus.dout, vecs[i].exp_dout);
            $display("vec %0d we=%0b addr=%0d din=0x%0h irq=0x%0h ack=%0b hw_int=0x%0h dout=0x%0h",
                     i, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].irq, vecs[i].ack,
                     bus.hw_int, bus.dout);
        end

        step(1'b0, 2'd3, 32'h0, 6'h05, 1'b0);
        chk("svc_status", bus.dout, 32'h201);

        @(negedge clk);
        reset = 1'b0;
        irq_in = 6'h00;
        bus.addr = 2'd3;
        @(posedge clk);
        #1;
        chk("rst_svc_status", bus.dout, 32'h0);
        chk("rst_svc_hw_int", {26'b0, bus.hw_int}, 32'h0);
        bus.addr = 2'd0;
        #1;
        chk("rst_svc_pend", bus.dout, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        $display("mid-service reset applied");

        step(1'b1, 2'd3, 32'h0, 6'h00, 1'b0);
        chk("post_rst_eoi_hw", {26'b0, bus.hw_int}, 32'h0);
        chk("post_rst_eoi_status", bus.dout, 32'h0);
        step(1'b0, 2'd3, 32'h0, 6'h00, 1'b0);
        chk("post_rst_idle_status", bus.dout, 32'h0);
        chk("post_rst_idle_req", {31'b0, bus.int_req}, 32'h0);
        $display("post-reset EOI write status=0x%0h hw_int=0x%0h", bus.dout, bus.hw_int);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
